// File: rtl/state_serializer.sv
// state_serializer
//   Captures a contiguous window of 64-bit permutation state lanes into a
//   shadow register and streams it out as OUT_W-bit words over a
//   valid/ready handshake. Lanes go out lowest index first, each lane
//   MSB-first.
//
// Parameters
//   OUT_W      : output word width (8, 16, 32 or 64)
//   NUM_LANES  : number of lanes emitted (1..5)
//   FIRST_LANE : index of the first lane emitted (FIRST_LANE+NUM_LANES <= 5)
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   S_0_reg..S_4_reg : state lanes, sampled only when a capture is accepted
//   start      : capture request, honoured only when idle
//   flush      : synchronous abort, beats start and a handshake
//   out_ready  : downstream accept
//   out_valid  : word presented (high exactly while sending)
//   out_data   : current word, zero while idle
//   out_last   : current word is the final word of the transaction
//   busy       : transaction in progress
//   key        : finalization key (only with SERIALIZER_KEY_XOR_EN)
//
// Build option
//   SERIALIZER_KEY_XOR_EN : when defined, adds port key and XORs the last two
//   captured lanes with it (single-lane builds XOR the lane with key[63:0]).
module state_serializer #(
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned FIRST_LANE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      S_0_reg,
    input  logic [63:0]      S_1_reg,
    input  logic [63:0]      S_2_reg,
    input  logic [63:0]      S_3_reg,
    input  logic [63:0]      S_4_reg,
    input  logic             start,
    input  logic             flush,
    input  logic             out_ready,
`ifdef SERIALIZER_KEY_XOR_EN
    input  logic [127:0]     key,
`endif
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned SHADOW_W = NUM_LANES * 64;
    localparam int unsigned N_WORDS  = SHADOW_W / OUT_W;
    localparam int unsigned CNT_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int unsigned LANE_TOP = 320 - 1 - FIRST_LANE * 64;

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_WORDS - 1);

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SHADOW_W-1:0] shadow_q, shadow_d;

    // Lane 0 sits at the top so the selected window is already in emit order.
    logic [319:0]        all_lanes;
    logic [SHADOW_W-1:0] snap;
    logic [SHADOW_W-1:0] key_mask;
    logic                last_word;
    logic                unused_lanes;

    assign all_lanes    = {S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg};
    assign unused_lanes = ^all_lanes;

`ifdef SERIALIZER_KEY_XOR_EN
    // Key right-aligned against the shadow: key[63:0] lands on the last lane,
    // key[127:64] on the one before it. A single lane only sees key[63:0].
    logic [SHADOW_W+127:0] key_wide;
    logic                  unused_key_wide;

    assign key_wide        = {{SHADOW_W{1'b0}}, key};
    assign key_mask        = key_wide[SHADOW_W-1:0];
    assign unused_key_wide = ^key_wide[SHADOW_W+127:SHADOW_W];
`else
    assign key_mask = '0;
`endif

    assign snap      = all_lanes[LANE_TOP -: SHADOW_W] ^ key_mask;
    assign last_word = (cnt_q == LastIdx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;

        if (flush) begin
            state_d  = StIdle;
            cnt_d    = '0;
            shadow_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d  = StSend;
                        cnt_d    = '0;
                        shadow_d = snap;
                    end
                end
                StSend: begin
                    // start is deliberately not looked at here, including on
                    // the final handshake.
                    if (out_ready) begin
                        // Shift so the next word is always at the top.
                        shadow_d = shadow_q << OUT_W;
                        if (last_word) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs decode from registered state only, so reset clears them at once
    // and they cannot move while a word is stalled.
    always_comb begin
        out_valid = (state_q == StSend);
        busy      = out_valid;
        out_last  = out_valid & last_word;
        out_data  = out_valid ? shadow_q[SHADOW_W-1 -: OUT_W] : '0;
    end

endmodule
